// File: rtl/stp_multi_if.sv
// stp_multi_if: request, memory-write and completion signals of the multi-register
// store engine, bundled into one interface.
//   master : request source and memory model side
//            (drives req_*, mem_wr_ready and mem_wr_ack)
//   slave  : the stp_multi engine
//            (drives req_ready, mem_wr_*, done_*, busy)
// Optional writeback signals (req_wb, wb_valid, wb_addr) are present only when
// the macro STP_WRITEBACK_EN is defined.
interface stp_multi_if #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned ADDR_W   = 48,
   parameter int unsigned NUM_REGS = 4
);
   localparam int unsigned CNT_W = $clog2(NUM_REGS) + 1;
   localparam int unsigned VEC_W = NUM_REGS * DATA_W;

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [CNT_W-1:0]  req_count;
   logic [VEC_W-1:0]  req_data;
   logic [7:0]        req_tag;
   logic              mem_wr_valid;
   logic              mem_wr_ready;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic              mem_wr_ack;
   logic              done_valid;
   logic [7:0]        done_tag;
   logic              busy;
`ifdef STP_WRITEBACK_EN
   logic              req_wb;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
`endif

   modport master (
      output req_valid, req_addr, req_count, req_data, req_tag, mem_wr_ready, mem_wr_ack,
`ifdef STP_WRITEBACK_EN
      output req_wb,
      input  wb_valid, wb_addr,
`endif
      input  req_ready, mem_wr_valid, mem_wr_addr, mem_wr_data, done_valid, done_tag, busy
   );

   modport slave (
      input  req_valid, req_addr, req_count, req_data, req_tag, mem_wr_ready, mem_wr_ack,
`ifdef STP_WRITEBACK_EN
      input  req_wb,
      output wb_valid, wb_addr,
`endif
      output req_ready, mem_wr_valid, mem_wr_addr, mem_wr_data, done_valid, done_tag, busy
   );
endinterface

// File: rtl/stp_multi.sv
// stp_multi: multi-register store engine. Queues store requests of up to NUM_REGS
// registers in a REQ_DEPTH-entry FIFO, serialises each into consecutive write
// beats at stride DATA_W/8 bytes, keeps at most MAX_OUT beats unacknowledged and
// pulses done_valid/done_tag once every beat of a request is acknowledged.
// Ports:
//   clk   : clock
//   reset : synchronous active-low reset
//   bus   : stp_multi_if.slave (request, memory write, ack, completion, busy)
// Optional feature macro STP_WRITEBACK_EN: adds req_wb/wb_valid/wb_addr to report
// the post-indexed base address alongside the done pulse.
module stp_multi #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned ADDR_W    = 48,
   parameter int unsigned NUM_REGS  = 4,
   parameter int unsigned REQ_DEPTH = 4,
   parameter int unsigned MAX_OUT   = 8
) (
   input logic        clk,
   input logic        reset,
   stp_multi_if.slave bus
);
   localparam int unsigned CNT_W  = $clog2(NUM_REGS) + 1;
   localparam int unsigned PTR_W  = $clog2(REQ_DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;
   localparam int unsigned OUT_W  = $clog2(MAX_OUT + 1);
   localparam int unsigned STRIDE = DATA_W / 8;
   localparam int unsigned VEC_W  = NUM_REGS * DATA_W;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   // request FIFO storage
   logic [ADDR_W-1:0] fifo_addr  [REQ_DEPTH];
   logic [CNT_W-1:0]  fifo_count [REQ_DEPTH];
   logic [VEC_W-1:0]  fifo_data  [REQ_DEPTH];
   logic [7:0]        fifo_tag   [REQ_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  level;

   // request currently being issued
   state_t            state;
   logic [ADDR_W-1:0] work_addr;
   logic [CNT_W-1:0]  work_count;
   logic [VEC_W-1:0]  work_data;
   logic [7:0]        work_tag;
   logic [CNT_W-1:0]  idx;
   logic [OUT_W-1:0]  outstanding;
`ifdef STP_WRITEBACK_EN
   logic              fifo_wb [REQ_DEPTH];
   logic              work_wb;
`endif

   logic              push_c;
   logic              pop_c;
   logic              hs_c;
   logic              ack_c;
   logic              to_idle_c;
   logic [CNT_W-1:0]  clamp_c;
   logic [CNT_W-1:0]  idx_next_c;
   logic [OUT_W-1:0]  out_next_c;
   logic [LVL_W-1:0]  level_next_c;
   logic [ADDR_W-1:0] beat_addr_c;
   logic [DATA_W-1:0] beat_data_c;

   // handshakes, counters and next-beat address/data
   always_comb begin
      push_c       = bus.req_valid && bus.req_ready;
      pop_c        = (state == IDLE) && (level != '0);
      hs_c         = (state == ISSUE) && bus.mem_wr_valid && bus.mem_wr_ready;
      // an ack with nothing outstanding is stray and dropped
      ack_c        = bus.mem_wr_ack && (outstanding != '0);
      clamp_c      = (bus.req_count > CNT_W'(NUM_REGS)) ? CNT_W'(NUM_REGS) : bus.req_count;
      idx_next_c   = idx + CNT_W'(hs_c);
      out_next_c   = outstanding + OUT_W'(hs_c) - OUT_W'(ack_c);
      level_next_c = level + LVL_W'(push_c) - LVL_W'(pop_c);
      to_idle_c    = ((state == IDLE) && !pop_c) || ((state == DRAIN) && (out_next_c == '0));
      beat_addr_c  = work_addr + ADDR_W'(idx_next_c) * ADDR_W'(STRIDE);
      beat_data_c  = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (idx_next_c == CNT_W'(i)) beat_data_c = work_data[i*DATA_W +: DATA_W];
      end
   end

   // FIFO, FSM and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state            <= IDLE;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         level            <= '0;
         outstanding      <= '0;
         idx              <= '0;
         work_addr        <= '0;
         work_count       <= '0;
         work_data        <= '0;
         work_tag         <= '0;
         bus.req_ready    <= 1'b1;
         bus.mem_wr_valid <= 1'b0;
         bus.mem_wr_addr  <= '0;
         bus.mem_wr_data  <= '0;
         bus.done_valid   <= 1'b0;
         bus.done_tag     <= '0;
         bus.busy         <= 1'b0;
`ifdef STP_WRITEBACK_EN
         work_wb          <= 1'b0;
         bus.wb_valid     <= 1'b0;
         bus.wb_addr      <= '0;
`endif
      end else begin
         outstanding    <= out_next_c;
         level          <= level_next_c;
         bus.req_ready  <= (level_next_c != LVL_W'(REQ_DEPTH));
         bus.busy       <= (level_next_c != '0) || !to_idle_c;
         bus.done_valid <= 1'b0;
`ifdef STP_WRITEBACK_EN
         bus.wb_valid   <= 1'b0;
         bus.wb_addr    <= '0;
`endif

         if (push_c) begin
            fifo_addr[wr_ptr]  <= bus.req_addr;
            fifo_count[wr_ptr] <= clamp_c;
            fifo_data[wr_ptr]  <= bus.req_data;
            fifo_tag[wr_ptr]   <= bus.req_tag;
`ifdef STP_WRITEBACK_EN
            fifo_wb[wr_ptr]    <= bus.req_wb;
`endif
            wr_ptr             <= wr_ptr + PTR_W'(1);
         end

         case (state)
            IDLE: begin
               if (pop_c) begin
                  work_addr  <= fifo_addr[rd_ptr];
                  work_count <= fifo_count[rd_ptr];
                  work_data  <= fifo_data[rd_ptr];
                  work_tag   <= fifo_tag[rd_ptr];
`ifdef STP_WRITEBACK_EN
                  work_wb    <= fifo_wb[rd_ptr];
`endif
                  rd_ptr     <= rd_ptr + PTR_W'(1);
                  idx        <= '0;
                  if (fifo_count[rd_ptr] == '0) begin
                     state <= DRAIN;
                  end else begin
                     // first beat comes straight from the FIFO head
                     state            <= ISSUE;
                     bus.mem_wr_valid <= (out_next_c < OUT_W'(MAX_OUT));
                     bus.mem_wr_addr  <= fifo_addr[rd_ptr];
                     bus.mem_wr_data  <= fifo_data[rd_ptr][DATA_W-1:0];
                  end
               end
            end
            ISSUE: begin
               idx <= idx_next_c;
               if (hs_c && (idx_next_c == work_count)) begin
                  state            <= DRAIN;
                  bus.mem_wr_valid <= 1'b0;
               end else begin
                  // valid follows the outstanding limit; addr/data move only on a handshake
                  bus.mem_wr_valid <= (out_next_c < OUT_W'(MAX_OUT));
                  if (hs_c) begin
                     bus.mem_wr_addr <= beat_addr_c;
                     bus.mem_wr_data <= beat_data_c;
                  end
               end
            end
            DRAIN: begin
               if (out_next_c == '0) begin
                  state          <= IDLE;
                  bus.done_valid <= 1'b1;
                  bus.done_tag   <= work_tag;
`ifdef STP_WRITEBACK_EN
                  bus.wb_valid   <= work_wb;
                  bus.wb_addr    <= work_addr + ADDR_W'(work_count) * ADDR_W'(STRIDE);
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
